final_image_write_ctrl: RTL

- Sequencer and arbiter in front of the final-image memory write port (CLK/WE/wA/WD style, 8-bit address, 8-bit data).
- Shares that single write port between two requesters:
  - a streaming pixel source, which writes consecutive addresses from a programmed base for a programmed length;
  - a direct random-access writer, for header or patch bytes.
- Sits between the pixel-processing datapath and the final-image memory; raises a one-cycle done pulse when a frame stream completes.

---
 rtl/final_image_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/final_image_write_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/final_image_pkg.sv
// Shared types and default widths for the final-image write controller.
package final_image_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_S = 1'b0,
        GRANT_D = 1'b1
    } grant_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is the stream, bit 1 the direct writer.
module rr_arbiter2
    import final_image_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    grant_t last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_D;
        end else if (accept) begin
            last_grant <= grant[1] ? GRANT_D : GRANT_S;
        end
    end
endmodule

// File: rtl/final_image_write_ctrl.sv
// Stream/direct sequencer in front of the final-image memory write port.
// Optional running stream checksum output when FINAL_IMG_CHECKSUM_EN is defined.
module final_image_write_ctrl
    import final_image_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              d_ready,
    output logic              busy,
    output logic              done,
    output logic              WE,
    output logic [ADDR_W-1:0] wA,
    output logic [DATA_W-1:0] WD,
`ifdef FINAL_IMG_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [1:0]        dbg_state
);
    state_t            state;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        grant;
    logic              s_acc;
    logic              d_acc;
    logic              last_word;

    // Handshake: a word transfers on a cycle where valid && ready; ready is the
    // arbiter grant and never depends on anything but valid, state and last_grant.
    rr_arbiter2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    ({d_valid, s_valid && (state == STREAM)}),
        .accept (s_acc || d_acc),
        .grant  (grant)
    );

    assign s_ready   = grant[0];
    assign d_ready   = grant[1];
    assign s_acc     = s_valid && s_ready;
    assign d_acc     = d_valid && d_ready;
    assign last_word = (count == len_q - LEN_W'(1));
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            len_q  <= '0;
            base_q <= '0;
            WE     <= 1'b0;
            wA     <= '0;
            WD     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        count  <= '0;
                        busy   <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (s_acc) begin
                        count <= count + LEN_W'(1);
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            // Stream address wraps naturally in ADDR_W bits.
            if (s_acc) begin
                WE <= 1'b1;
                wA <= base_q + count[ADDR_W-1:0];
                WD <= s_data;
            end else if (d_acc) begin
                WE <= 1'b1;
                wA <= d_addr;
                WD <= d_data;
            end else begin
                WE <= 1'b0;
            end
        end
    end

`ifdef FINAL_IMG_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            checksum <= '0;
        end else if ((state == IDLE) && start) begin
            checksum <= '0;
        end else if (s_acc) begin
            checksum <= checksum + s_data;
        end
    end
`endif
endmodule
